// File: rtl/atr_sequencer16.sv
// ATR control-line driver: maps {run_rx,run_tx} to one of four modes and commits each
// mode's control word after a programmable settle delay. 16-bit Wishbone slave for config.
module atr_sequencer16 #(
   parameter int CTRL_W  = 32,
   parameter int DELAY_W = 16
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic [5:0]        adr_i,
   input  logic [1:0]        sel_i,
   input  logic [15:0]       dat_i,
   output logic [15:0]       dat_o,
   input  logic              we_i,
   input  logic              stb_i,
   input  logic              cyc_i,
   output logic              ack_o,
   input  logic              run_rx,
   input  logic              run_tx,
   output logic [CTRL_W-1:0] ctrl_lines,
   output logic              busy
);

   typedef enum logic {
      SEQ_IDLE  = 1'b0,
      SEQ_COUNT = 1'b1
   } seq_state_t;

   logic [CTRL_W-1:0]  mode_word [4];
   logic [DELAY_W-1:0] delay_q   [4];
   logic [2:0]         force_q;   // {force_mode[1:0], force_en}

   seq_state_t         state, state_n;
   logic [1:0]         cur_mode, cur_mode_n;
   logic [1:0]         target, target_n;
   logic [DELAY_W-1:0] cnt, cnt_n;

   logic               wb_acc, wb_wr;
   logic [3:0]         word_idx;
   logic [31:0]        wr_data, wr_mask, rd_word;
   logic [1:0]         req;
   logic [DELAY_W-1:0] req_delay;
   logic               unused_adr;

   assign wb_acc     = stb_i & cyc_i;
   assign wb_wr      = wb_acc & we_i;
   assign word_idx   = adr_i[5:2];
   assign unused_adr = adr_i[0];
   assign wr_data    = {dat_i, dat_i};
   // Byte lanes land in the upper or lower half of the 32-bit register view.
   assign wr_mask    = adr_i[1] ? {{8{sel_i[1]}}, {8{sel_i[0]}}, 16'h0000}
                                : {16'h0000, {8{sel_i[1]}}, {8{sel_i[0]}}};

   assign req        = {run_rx, run_tx};
   assign req_delay  = delay_q[req];
   assign busy       = (state == SEQ_COUNT);
   assign ctrl_lines = mode_word[cur_mode];

   // NOTE: the mode/delay file is only 8 words and must read 0 out of reset, so it is
   // built from resettable flops rather than left to a RAM macro.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         for (int i = 0; i < 4; i++) begin
            mode_word[i] <= '0;
            delay_q[i]   <= '0;
         end
         force_q <= '0;
      end else if (wb_wr) begin
         case (word_idx)
            4'd0, 4'd1, 4'd2, 4'd3:
               mode_word[word_idx[1:0]] <= (mode_word[word_idx[1:0]] & ~wr_mask[CTRL_W-1:0])
                                         | (wr_data[CTRL_W-1:0] & wr_mask[CTRL_W-1:0]);
            4'd4, 4'd5, 4'd6, 4'd7:
               delay_q[word_idx[1:0]] <= (delay_q[word_idx[1:0]] & ~wr_mask[DELAY_W-1:0])
                                       | (wr_data[DELAY_W-1:0] & wr_mask[DELAY_W-1:0]);
            4'd9:
               force_q <= (force_q & ~wr_mask[2:0]) | (wr_data[2:0] & wr_mask[2:0]);
            default: ;
         endcase
      end
   end

   always_comb begin
      rd_word = '0;
      case (word_idx)
         4'd0, 4'd1, 4'd2, 4'd3: rd_word = 32'(mode_word[word_idx[1:0]]);
         4'd4, 4'd5, 4'd6, 4'd7: rd_word = 32'(delay_q[word_idx[1:0]]);
         4'd8:                   rd_word = {27'b0, busy, target, cur_mode};
         4'd9:                   rd_word = {29'b0, force_q};
         default:                rd_word = '0;
      endcase
   end

   // NOTE: sequential state is updated with non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         ack_o <= 1'b0;
         dat_o <= '0;
      end else begin
         ack_o <= wb_acc & ~ack_o;
         if (wb_acc) dat_o <= adr_i[1] ? rd_word[31:16] : rd_word[15:0];
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state    <= SEQ_IDLE;
         cur_mode <= 2'd0;
         target   <= 2'd0;
         cnt      <= '0;
      end else begin
         state    <= state_n;
         cur_mode <= cur_mode_n;
         target   <= target_n;
         cnt      <= cnt_n;
      end
   end

   // NOTE: every output of this block is defaulted first so no path infers a latch.
   always_comb begin
      state_n    = state;
      cur_mode_n = cur_mode;
      target_n   = target;
      cnt_n      = cnt;
      if (force_q[0]) begin
         cur_mode_n = force_q[2:1];
         cnt_n      = '0;
         state_n    = SEQ_IDLE;
      end else begin
         case (state)
            SEQ_IDLE: begin
               if (req != cur_mode) begin
                  if (req_delay == '0) begin
                     cur_mode_n = req;
                  end else begin
                     target_n = req;
                     cnt_n    = req_delay;
                     state_n  = SEQ_COUNT;
                  end
               end
            end
            SEQ_COUNT: begin
               if (req == cur_mode) begin
                  cnt_n   = '0;
                  state_n = SEQ_IDLE;
               end else if (req != target) begin
                  target_n = req;
                  if (req_delay == '0) begin
                     cur_mode_n = req;
                     cnt_n      = '0;
                     state_n    = SEQ_IDLE;
                  end else begin
                     cnt_n = req_delay;
                  end
               end else if (cnt == DELAY_W'(1)) begin
                  cur_mode_n = target;
                  cnt_n      = '0;
                  state_n    = SEQ_IDLE;
               end else begin
                  cnt_n = cnt - DELAY_W'(1);
               end
            end
            default: state_n = SEQ_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_atr_sequencer16.sv
// Scoreboard bench for atr_sequencer16: stimulus queues expected read data and output
// snapshots; a monitor pops them on read acks and on each falling edge.
module tb_atr_sequencer16;

   logic        clk_i = 1'b0;
   logic        rst_n_i = 1'b0;
   logic [5:0]  adr_i = '0;
   logic [1:0]  sel_i = '0;
   logic [15:0] dat_i = '0;
   logic [15:0] dat_o;
   logic        we_i = 1'b0, stb_i = 1'b0, cyc_i = 1'b0;
   logic        ack_o;
   logic        run_rx = 1'b0, run_tx = 1'b0;
   logic [31:0] ctrl_lines;
   logic        busy;

   typedef struct {
      string       name;
      logic [31:0] ctrl;
      logic        busy;
   } obs_t;

   typedef struct {
      string       name;
      logic [15:0] data;
   } rd_t;

   obs_t obs_q[$];
   rd_t  rd_q[$];
   int   n_vec  = 0;
   int   n_miss = 0;

   atr_sequencer16 #(.CTRL_W(32), .DELAY_W(16)) dut (
      .clk_i      (clk_i),
      .rst_n_i    (rst_n_i),
      .adr_i      (adr_i),
      .sel_i      (sel_i),
      .dat_i      (dat_i),
      .dat_o      (dat_o),
      .we_i       (we_i),
      .stb_i      (stb_i),
      .cyc_i      (cyc_i),
      .ack_o      (ack_o),
      .run_rx     (run_rx),
      .run_tx     (run_tx),
      .ctrl_lines (ctrl_lines),
      .busy       (busy)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Monitor: read data is compared when the DUT acks a read; output snapshots each falling edge.
   initial begin : monitor
      logic rd_strobe;
      obs_t o;
      rd_t  r;
      forever begin
         @(posedge clk_i);
         rd_strobe = stb_i && cyc_i && !we_i;
         @(negedge clk_i);
         if (ack_o && rd_strobe) begin
            if (rd_q.size() == 0) begin
               n_vec++;
               n_miss++;
               $display("FAIL unexpected_ack: got read ack, expected none pending");
            end else begin
               r = rd_q.pop_front();
               check(r.name, 32'(dat_o), 32'(r.data));
            end
         end
         while (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            check({o.name, ".ctrl"}, ctrl_lines, o.ctrl);
            check({o.name, ".busy"}, 32'(busy), 32'(o.busy));
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got no completion, expected finish");
      $fatal(1, "timeout");
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk_i);
         #1;
      end
   endtask

   task automatic expect_out(input string name, input logic [31:0] c, input logic b);
      obs_t o;
      o.name = name;
      o.ctrl = c;
      o.busy = b;
      obs_q.push_back(o);
   endtask

   task automatic wb_write(input logic [5:0] a, input logic [1:0] s, input logic [15:0] d);
      adr_i = a; sel_i = s; dat_i = d;
      we_i = 1'b1; stb_i = 1'b1; cyc_i = 1'b1;
      step(1);
      we_i = 1'b0; stb_i = 1'b0; cyc_i = 1'b0;
      step(1);
   endtask

   task automatic wb_read(input logic [5:0] a, input logic [15:0] exp, input string name,
                          input int hold);
      rd_t r;
      r.name = name;
      r.data = exp;
      rd_q.push_back(r);
      adr_i = a; sel_i = 2'b11;
      we_i = 1'b0; stb_i = 1'b1; cyc_i = 1'b1;
      step(hold);
      stb_i = 1'b0; cyc_i = 1'b0;
      step(1);
   endtask

   initial begin : stimulus
      expect_out("reset", 32'h0, 1'b0);
      step(3);
      rst_n_i = 1'b1;
      wb_read(6'h20, 16'h0000, "status_reset", 1);
      wb_read(6'h00, 16'h0000, "word0_reset", 1);

      // Zero-delay mode switch: IDLE -> TX in one edge
      wb_write(6'h04, 2'b11, 16'h0F0F);
      wb_write(6'h06, 2'b11, 16'hA5A5);
      wb_read(6'h06, 16'hA5A5, "word1_hi", 1);
      run_tx = 1'b1;
      expect_out("t1_pre", 32'h0, 1'b0);
      step(1);
      expect_out("t1_commit", 32'hA5A5_0F0F, 1'b0);
      step(1);
      expect_out("t1_hold", 32'hA5A5_0F0F, 1'b0);

      // Delay 5 TX -> RX; rewriting delay2 mid-countdown has no effect
      wb_write(6'h18, 2'b11, 16'd5);
      wb_write(6'h08, 2'b11, 16'h1234);
      run_rx = 1'b1;
      run_tx = 1'b0;
      step(1);
      expect_out("t2_e0", 32'hA5A5_0F0F, 1'b1);
      wb_write(6'h18, 2'b11, 16'd1);
      expect_out("t2_e2", 32'hA5A5_0F0F, 1'b1);
      for (int i = 3; i <= 4; i++) begin
         step(1);
         expect_out($sformatf("t2_e%0d", i), 32'hA5A5_0F0F, 1'b1);
      end
      step(1);
      expect_out("t2_commit", 32'h0000_1234, 1'b0);

      // FDX countdown restarted to TX (delay 0): immediate commit, FDX word never shown
      wb_write(6'h1C, 2'b11, 16'd10);
      wb_write(6'h0C, 2'b11, 16'hFDFD);
      wb_write(6'h0E, 2'b11, 16'hFDFD);
      run_tx = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step(1);
         expect_out($sformatf("t3_e%0d", i), 32'h0000_1234, 1'b1);
      end
      run_rx = 1'b0;
      step(1);
      expect_out("t3_restart", 32'hA5A5_0F0F, 1'b0);

      // Abort: TX countdown (delay 8) cancelled by returning to IDLE
      wb_write(6'h00, 2'b11, 16'hC3C3);
      wb_write(6'h14, 2'b11, 16'd8);
      run_tx = 1'b0;
      step(1);
      expect_out("t4_idle", 32'h0000_C3C3, 1'b0);
      run_tx = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step(1);
         expect_out($sformatf("t4_e%0d", i), 32'h0000_C3C3, 1'b1);
      end
      run_tx = 1'b0;
      step(1);
      expect_out("t4_abort", 32'h0000_C3C3, 1'b0);
      wb_read(6'h20, 16'h0004, "t4_status", 1);

      // Force mode 2 while run_tx requests TX, then release and resequence
      run_tx = 1'b1;
      wb_write(6'h24, 2'b01, 16'h0005);
      expect_out("t5_forced", 32'h0000_1234, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step(1);
         expect_out($sformatf("t5_hold%0d", i), 32'h0000_1234, 1'b0);
      end
      wb_read(6'h24, 16'h0005, "t5_force_rb", 1);
      wb_write(6'h24, 2'b01, 16'h0000);
      expect_out("t5_reseq", 32'h0000_1234, 1'b1);
      for (int i = 0; i < 7; i++) begin
         step(1);
         expect_out($sformatf("t5_cnt%0d", i), 32'h0000_1234, 1'b1);
      end
      step(1);
      expect_out("t5_commit", 32'hA5A5_0F0F, 1'b0);

      // Partial writes, dropped bits, unmapped words, held strobe
      wb_write(6'h02, 2'b01, 16'h5A77);
      wb_read(6'h02, 16'h0077, "t6_w0_hi", 1);
      wb_read(6'h00, 16'hC3C3, "t6_w0_lo", 1);
      wb_write(6'h00, 2'b10, 16'h11FF);
      wb_read(6'h00, 16'h11C3, "t6_w0_lo_held", 2);
      wb_write(6'h16, 2'b11, 16'hFFFF);
      wb_read(6'h16, 16'h0000, "t6_delay1_hi", 1);
      wb_read(6'h14, 16'h0008, "t6_delay1_lo", 1);
      wb_write(6'h30, 2'b11, 16'hBEEF);
      wb_read(6'h30, 16'h0000, "t6_word12", 1);

      // Status mid-countdown, then asynchronous reset
      wb_write(6'h10, 2'b11, 16'd3);
      run_tx = 1'b0;
      step(1);
      expect_out("t6_e0", 32'hA5A5_0F0F, 1'b1);
      wb_read(6'h20, 16'h0011, "t6_status_busy", 1);
      rst_n_i = 1'b0;
      expect_out("t6_reset", 32'h0, 1'b0);
      step(2);
      rst_n_i = 1'b1;
      wb_read(6'h00, 16'h0000, "t6_word0_rst", 1);
      wb_read(6'h20, 16'h0000, "t6_status_rst", 1);
      expect_out("t6_post_rst", 32'h0, 1'b0);

      step(3);
      check("pending_reads", 32'(rd_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
